// File: rtl/vec_regfile_seq.sv
// vec_regfile_seq: vector register file with grouped combinational reads,
// a sequenced byte-enable group write port and a single-cycle v0 update.
module vec_regfile_seq #(
    parameter int VLEN     = 512,
    parameter int NREG     = 32,
    parameter int MAX_LMUL = 8,
    parameter int AW       = $clog2(NREG)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AW-1:0]              raddr_1,
    input  logic [AW-1:0]              raddr_2,
    input  logic [3:0]                 lmul,
    output logic [MAX_LMUL*VLEN-1:0]   rdata_1,
    output logic [MAX_LMUL*VLEN-1:0]   rdata_2,
    output logic [MAX_LMUL*VLEN-1:0]   dst_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [AW-1:0]              waddr,
    input  logic [MAX_LMUL*VLEN-1:0]   wdata,
    input  logic [MAX_LMUL*VLEN/8-1:0] wbe,
    input  logic                       wr_v0_en,
    input  logic                       mask_wr_en,
    output logic [VLEN-1:0]            v0_mask_data,
    output logic                       rd_err,
    output logic                       wr_err,
    output logic                       wr_done
);
    localparam int GW = MAX_LMUL * VLEN;
    localparam int VB = VLEN / 8;
    localparam int KW = $clog2(MAX_LMUL) + 1;

    typedef enum logic {IDLE, WRITE} state_t;
    state_t state, state_n;

    logic [VLEN-1:0] regs [NREG];
    logic [AW-1:0]   cap_base;
    logic [3:0]      cap_lmul;
    logic [GW-1:0]   cap_data;
    logic [GW/8-1:0] cap_be;
    logic            cap_v0_en;
    logic [KW-1:0]   k;
    logic            wr_legal;
    logic            last;
    logic            skip;
    logic [AW-1:0]   wr_idx;

    // Non-one-hot or oversize LMUL decodes to 0, i.e. illegal.
    function automatic int grp_len(input logic [3:0] m);
        int len;
        len = 0;
        if ($onehot(m)) begin
            unique case (1'b1)
                m[0]:    len = 1;
                m[1]:    len = 2;
                m[2]:    len = 4;
                m[3]:    len = 8;
                default: len = 0;
            endcase
        end
        return (len > MAX_LMUL) ? 0 : len;
    endfunction

    function automatic logic grp_ok(input logic [AW-1:0] base,
                                    input logic [3:0] m);
        int len;
        int b;
        len = grp_len(m);
        b   = int'(base);
        if (len == 0)
            return 1'b0;
        return ((b & (len - 1)) == 0) && (b + len <= NREG);
    endfunction

    function automatic logic [GW-1:0] grp_read(input logic [AW-1:0] base,
                                               input logic [3:0] m);
        logic [GW-1:0] d;
        int len;
        d   = '0;
        len = grp_len(m);
        if (grp_ok(base, m)) begin
            for (int i = 0; i < MAX_LMUL; i++) begin
                if (i < len)
                    d[i*VLEN +: VLEN] = regs[AW'(int'(base) + i)];
            end
        end
        return d;
    endfunction

    assign rdata_1      = grp_read(raddr_1, lmul);
    assign rdata_2      = grp_read(raddr_2, lmul);
    assign dst_data     = grp_read(waddr, lmul);
    assign rd_err       = !(grp_ok(raddr_1, lmul) &&
                            grp_ok(raddr_2, lmul) &&
                            grp_ok(waddr, lmul));
    assign v0_mask_data = regs[0];

    assign wr_legal = grp_ok(waddr, lmul);
    assign last     = int'(k) == grp_len(cap_lmul) - 1;
    assign wr_idx   = AW'(int'(cap_base) + int'(k));
    assign skip     = (cap_base == '0) && (k == '0) && !cap_v0_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (!mask_wr_en && wr_valid && wr_legal)
                    state_n = WRITE;
            end
            WRITE: begin
                if (last)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A pending mask update steals the IDLE slot from the group request.
    always_comb begin
        wr_ready = (state == IDLE) && !mask_wr_en;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            cap_base  <= '0;
            cap_lmul  <= '0;
            cap_data  <= '0;
            cap_be    <= '0;
            cap_v0_en <= 1'b0;
            k         <= '0;
            wr_err    <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            wr_err  <= 1'b0;
            wr_done <= 1'b0;
            if (state == IDLE) begin
                if (mask_wr_en) begin
                    regs[0] <= wdata[VLEN-1:0];
                    wr_done <= 1'b1;
                end else if (wr_valid) begin
                    if (wr_legal) begin
                        cap_base  <= waddr;
                        cap_lmul  <= lmul;
                        cap_data  <= wdata;
                        cap_be    <= wbe;
                        cap_v0_en <= wr_v0_en;
                        k         <= '0;
                    end else begin
                        wr_err <= 1'b1;
                    end
                end
            end else begin
                if (!skip) begin
                    for (int b = 0; b < VB; b++) begin
                        if (cap_be[int'(k)*VB + b])
                            regs[wr_idx][b*8 +: 8] <=
                                cap_data[int'(k)*VLEN + b*8 +: 8];
                    end
                end
                k <= k + KW'(1);
                if (last)
                    wr_done <= 1'b1;
            end
        end
    end

endmodule
